// File: rtl/half_subtractor_if.sv
// Operand/result bundle for the half subtractor: sampled operands with a
// valid strobe on one side, registered difference/borrow with a valid strobe
// on the other. There is no ready signal because the cell never stalls.
interface half_subtractor_if #(
  parameter int WIDTH = 1
);
  logic             inValid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] xy;
  logic [WIDTH-1:0] borrowOut;
  logic             outValid;

  // Producer of operands, consumer of results.
  modport master (
    output inValid, x, y,
    input  xy, borrowOut, outValid
  );

  // The half subtractor itself.
  modport slave (
    input  inValid, x, y,
    output xy, borrowOut, outValid
  );
endinterface

// File: rtl/half_subtractor.sv
// Bitwise half subtractor: WIDTH independent lanes computing x - y with no
// borrow-in. Per lane the difference is x ^ y and the borrow is ~x & y, so
// {borrow, difference} is the 2-bit two's-complement value of x - y.
// Results are registered once; outValid marks the cycle after an accepted
// input. Operands are only looked at when inValid is high, so garbage on x/y
// in idle cycles never reaches the outputs.
module half_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic              clock,
  input  logic              nReset,
  half_subtractor_if.slave  bus
);

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] borrow_next;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
  logic             valid;

  // Per-lane difference and borrow; no carry chain between lanes.
  always_comb begin
    // NOTE: every signal written here gets a value on every pass, so no latch can be inferred.
    diff_next   = bus.x ^ bus.y;
    borrow_next = ~bus.x & bus.y;
  end

  // Result register: load on an accepted input, otherwise hold.
  always_ff @(posedge clock or negedge nReset) begin
    // NOTE: the result registers are cleared by reset as well, so outputs read 0 rather than stale data after reset.
    if (!nReset) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      diff   <= '0;
      borrow <= '0;
    end else if (bus.inValid) begin
      diff   <= diff_next;
      borrow <= borrow_next;
    end
  end

  // Valid flag: follows inValid with one cycle of delay; reset drops any in-flight result.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      valid <= 1'b0;
    end else begin
      valid <= bus.inValid;
    end
  end

  assign bus.xy        = diff;
  assign bus.borrowOut = borrow;
  assign bus.outValid  = valid;

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: a 1-lane and a 4-lane instance share the clock and
// reset. A model process records the expected result of every accepted input
// in a per-instance queue. Monitors pop and compare on each falling edge
// whenever a result should be visible, and check that the outputs hold when it
// should not be. Directed checks cover reset, the truth table, holding, lane
// independence and mid-stream reset. Randomized traffic follows.
module tb_half_subtractor;

  typedef struct packed {
    logic [3:0] xy;
    logic [3:0] b;
  } exp_t;

  logic clock;
  logic nReset;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t last1;
  exp_t last4;

  half_subtractor_if #(.WIDTH(1)) bus1 ();
  half_subtractor_if #(.WIDTH(4)) bus4 ();

  half_subtractor #(.WIDTH(1)) dut1 (.clock(clock), .nReset(nReset), .bus(bus1));
  half_subtractor #(.WIDTH(4)) dut4 (.clock(clock), .nReset(nReset), .bus(bus4));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane's result is the integer x - y written as a 2-bit
  // two's-complement number; the low bit is the difference, the high bit the borrow.
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
    exp_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int d;
      logic [1:0] v;
      d = int'(x[i]) - int'(y[i]);
      v = 2'(d);
      r.xy[i] = v[0];
      r.b[i]  = v[1];
    end
    return r;
  endfunction

  // Drive both instances at a falling edge; the next rising edge samples.
  task automatic drive(input logic v1, input logic x1, input logic y1,
                       input logic v4, input logic [3:0] x4, input logic [3:0] y4);
    @(negedge clock);
    bus1.inValid = v1;
    bus1.x       = x1;
    bus1.y       = y1;
    bus4.inValid = v4;
    bus4.x       = x4;
    bus4.y       = y4;
  endtask

  task automatic expect_zero(input string tag);
    check({tag, " w1 xy"},       32'(bus1.xy),        32'd0);
    check({tag, " w1 borrow"},   32'(bus1.borrowOut), 32'd0);
    check({tag, " w1 outValid"}, 32'(bus1.outValid),  32'd0);
    check({tag, " w4 xy"},       32'(bus4.xy),        32'd0);
    check({tag, " w4 borrow"},   32'(bus4.borrowOut), 32'd0);
    check({tag, " w4 outValid"}, 32'(bus4.outValid),  32'd0);
  endtask

  // Model: record what each rising edge with reset released should capture.
  always @(posedge clock) begin
    if (nReset === 1'b1) begin
      if (bus1.inValid) q1.push_back(model({3'b000, bus1.x}, {3'b000, bus1.y}));
      if (bus4.inValid) q4.push_back(model(bus4.x, bus4.y));
    end
  end

  // Reset throws away anything captured but not yet observed.
  always @(negedge nReset) begin
    q1.delete();
    q4.delete();
    last1 = '0;
    last4 = '0;
  end

  // Monitor for the 1-lane instance.
  always @(negedge clock) begin
    logic exp_v;
    exp_v = (q1.size() != 0);
    check("w1 outValid", 32'(bus1.outValid), 32'(exp_v));
    if (exp_v) last1 = q1.pop_front();
    check("w1 xy",     32'(bus1.xy),        32'(last1.xy[0]));
    check("w1 borrow", 32'(bus1.borrowOut), 32'(last1.b[0]));
  end

  // Monitor for the 4-lane instance.
  always @(negedge clock) begin
    logic exp_v;
    exp_v = (q4.size() != 0);
    check("w4 outValid", 32'(bus4.outValid), 32'(exp_v));
    if (exp_v) last4 = q4.pop_front();
    check("w4 xy",     32'(bus4.xy),        32'(last4.xy));
    check("w4 borrow", 32'(bus4.borrowOut), 32'(last4.b));
  end

  initial begin
    logic [1:0] tt [4];
    tt[0] = 2'b00;   // {borrow, xy} for x=0,y=0
    tt[1] = 2'b11;   // x=0,y=1
    tt[2] = 2'b01;   // x=1,y=0
    tt[3] = 2'b00;   // x=1,y=1

    nReset       = 1'b1;
    bus1.inValid = 1'b0;
    bus1.x       = '0;
    bus1.y       = '0;
    bus4.inValid = 1'b0;
    bus4.x       = '0;
    bus4.y       = '0;
    last1        = '0;
    last4        = '0;
    #1 nReset = 1'b0;

    // Reset held with valid all-ones operands toggling; outputs stay clear,
    // including between edges.
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 1'b1, 1'b1, i[0], 4'hF, 4'hF);
      @(posedge clock);
      #2 expect_zero("reset held");
    end
    @(negedge clock);
    #2 nReset = 1'b1;

    // Exhaustive truth table on the single lane, back to back.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i > 0) begin
        check("tt xy",       32'(bus1.xy),        32'(tt[i-1][0]));
        check("tt borrow",   32'(bus1.borrowOut), 32'(tt[i-1][1]));
        check("tt outValid", 32'(bus1.outValid),  32'd1);
      end
      if (i < 4) begin
        bus1.inValid = 1'b1;
        bus1.x       = i[1];
        bus1.y       = i[0];
      end else begin
        bus1.inValid = 1'b0;
      end
    end

    // Hold: accept 0-1, then idle with different operands.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("hold load xy",     32'(bus1.xy),        32'd1);
    check("hold load borrow", 32'(bus1.borrowOut), 32'd1);
    drive(1'b0, 1'bx, 1'bx, 1'b0, 4'hx, 4'hx);
    check("hold xy",       32'(bus1.xy),        32'd1);
    check("hold borrow",   32'(bus1.borrowOut), 32'd1);
    check("hold outValid", 32'(bus1.outValid),  32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Independent lanes on the 4-lane instance.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 4'b1010);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    check("lanes xy",       32'(bus4.xy),        32'b0110);
    check("lanes borrow",   32'(bus4.borrowOut), 32'b0010);
    check("lanes outValid", 32'(bus4.outValid),  32'd1);

    // Mid-stream reset pulse between edges, then an idle cycle after release.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 4'b1110);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 4'b1111);
    @(posedge clock);
    #2 nReset = 1'b0;
    #1 expect_zero("midreset async");
    #1 nReset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    expect_zero("midreset after release");

    // Random traffic; idle cycles carry random operands that must be ignored.
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
